// File: rtl/movement_pulse_gen_if.sv
// Button-to-movement-controller signal bundle: raw button levels in,
// single-cycle movement commands and debounced levels out.
interface movement_pulse_gen_if;
  logic       btn_fwd;
  logic       btn_bwd;
  logic       btn_left;
  logic       btn_right;
  logic       fwd_pulse;
  logic       bwd_pulse;
  logic       leftRot_pulse;
  logic       rightRot_pulse;
  logic [3:0] btn_state;

  modport master (
    output btn_fwd, btn_bwd, btn_left, btn_right,
    input  fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse, btn_state
  );

  modport slave (
    input  btn_fwd, btn_bwd, btn_left, btn_right,
    output fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse, btn_state
  );
endinterface

// File: rtl/movement_pulse_gen.sv
// Debounces four movement buttons, generates press/auto-repeat requests and
// serialises them into gapped single-cycle pulses with fixed priority.
module movement_pulse_gen #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd10000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  movement_pulse_gen_if.slave  bus
);

  localparam int unsigned NBTN  = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMR_W = 24;

  localparam logic [CNT_W-1:0] DB_LAST     = DEBOUNCE_CYCLES - CNT_W'(1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = REPEAT_DELAY - TMR_W'(1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = REPEAT_PERIOD - TMR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [NBTN-1:0] raw_c;
  logic [NBTN-1:0] deb_c;
  logic [NBTN-1:0] req_set_c;
  logic [NBTN-1:0] grant_c;
  logic [NBTN-1:0] pend_q, pend_d;
  logic [NBTN-1:0] pulse_q, pulse_d;
  logic            gap_q, gap_d;

  assign raw_c = {bus.btn_right, bus.btn_left, bus.btn_bwd, bus.btn_fwd};

  for (genvar b = 0; b < NBTN; b++) begin : g_btn
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    state_t           state_q, state_d;
    logic             req_c;

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
        tmr_q   <= '0;
        state_q <= IDLE;
      end else begin
        sync1_q <= raw_c[b];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        tmr_q   <= tmr_d;
        state_q <= state_d;
      end
    end

    // Toggle the debounced level once the mismatch has persisted long enough.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q >= DB_LAST) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Hold FSM: one request on press, then delayed auto-repeat while held.
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      req_c   = 1'b0;
      if (!deb_q) begin
        state_d = IDLE;
        tmr_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = WAIT;
            req_c   = 1'b1;
            tmr_d   = '0;
          end
          WAIT: begin
            if (tmr_q >= DELAY_LAST) begin
              state_d = REPEAT;
              req_c   = 1'b1;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
          REPEAT: begin
            if (tmr_q >= PERIOD_LAST) begin
              req_c = 1'b1;
              tmr_d = '0;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
            tmr_d   = '0;
          end
        endcase
      end
    end

    assign deb_c[b]     = deb_q;
    assign req_set_c[b] = req_c;
  end

  // Fixed-priority arbiter; a pulse blocks the following cycle.
  always_comb begin
    grant_c = '0;
    if (!gap_q) begin
      if (pend_q[0])      grant_c = 4'b0001;
      else if (pend_q[1]) grant_c = 4'b0010;
      else if (pend_q[2]) grant_c = 4'b0100;
      else if (pend_q[3]) grant_c = 4'b1000;
    end
    pend_d  = (pend_q & ~grant_c) | req_set_c;
    pulse_d = grant_c;
    gap_d   = |grant_c;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_q  <= '0;
      pulse_q <= '0;
      gap_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.fwd_pulse      = pulse_q[0];
  assign bus.bwd_pulse      = pulse_q[1];
  assign bus.leftRot_pulse  = pulse_q[2];
  assign bus.rightRot_pulse = pulse_q[3];
  assign bus.btn_state      = deb_c;

endmodule

// File: tb/tb_movement_pulse_gen.sv
// Directed bench for movement_pulse_gen with short debounce/repeat timing;
// expected pulse cycles are computed by hand from the press cycle.
module tb_movement_pulse_gen;

  localparam logic [15:0] DB  = 16'd4;
  localparam logic [23:0] RD  = 24'd20;
  localparam logic [23:0] RP  = 24'd8;
  localparam int          LAT = 7;   // 2 sync + 4 debounce + 1 pending, pulse next

  logic clk_in = 1'b0;
  logic rst_in;

  movement_pulse_gen_if bus ();

  movement_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int viol   = 0;
  int nz_cnt = 0;
  int pcnt     [4];
  int last_cyc [4];
  int st_rise  [4];
  int right_q  [$];
  logic [3:0] prev_p  = 4'b0;
  logic [3:0] prev_st = 4'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Observe outputs shortly after each rising edge; cyc names the cycle.
  always @(posedge clk_in) begin
    logic [3:0] p;
    #2;
    cyc = cyc + 1;
    p = {bus.rightRot_pulse, bus.leftRot_pulse, bus.bwd_pulse, bus.fwd_pulse};
    if ($countones(p) > 1) viol++;
    if (p != 4'b0 && prev_p != 4'b0) viol++;
    if (bus.btn_state != 4'b0) nz_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        pcnt[i]++;
        last_cyc[i] = cyc;
      end
      if (bus.btn_state[i] && !prev_st[i]) st_rise[i] = cyc;
    end
    if (p[3]) right_q.push_back(cyc);
    prev_p  = p;
    prev_st = bus.btn_state;
  end

  function automatic int pulses_now();
    return int'({bus.rightRot_pulse, bus.leftRot_pulse, bus.bwd_pulse, bus.fwd_pulse});
  endfunction

  initial begin
    int n0, c0, c1, c2, c3, nz0, q0;
    int rep_off [6] = '{7, 27, 35, 43, 51, 59};

    for (int i = 0; i < 4; i++) begin
      pcnt[i] = 0; last_cyc[i] = -1; st_rise[i] = -1;
    end
    rst_in        = 1'b1;
    bus.btn_fwd   = 1'b0;
    bus.btn_bwd   = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;

    // Reset values
    run(3);
    check("rst_state", int'(bus.btn_state), 0);
    check("rst_pulse", pulses_now(), 0);
    rst_in = 1'b0;
    run(3);

    // Clean forward press and release
    c0 = pcnt[0]; n0 = cyc + 1;
    bus.btn_fwd = 1'b1;
    run(15);
    check("fwd_state_rise", st_rise[0], n0 + 5);
    check("fwd_pulse_cyc", last_cyc[0], n0 + LAT);
    check("fwd_pulse_cnt", pcnt[0] - c0, 1);
    check("fwd_state_held", int'(bus.btn_state), 1);
    bus.btn_fwd = 1'b0;
    run(10);
    check("fwd_state_rel", int'(bus.btn_state), 0);
    check("fwd_cnt_rel", pcnt[0] - c0, 1);

    // Three-cycle glitch is rejected
    c2 = pcnt[2]; nz0 = nz_cnt;
    bus.btn_left = 1'b1;
    run(3);
    bus.btn_left = 1'b0;
    run(12);
    check("glitch_state", nz_cnt - nz0, 0);
    check("glitch_pulse", pcnt[2] - c2, 0);

    // Four-cycle pulse is just long enough to register
    n0 = cyc + 1;
    bus.btn_left = 1'b1;
    run(4);
    bus.btn_left = 1'b0;
    run(15);
    check("min_press_cnt", pcnt[2] - c2, 1);
    check("min_press_cyc", last_cyc[2], n0 + LAT);
    check("min_press_state", int'(bus.btn_state), 0);

    // Auto-repeat on right, released before the sixth repeat
    q0 = right_q.size(); n0 = cyc + 1;
    bus.btn_right = 1'b1;
    run(56);
    bus.btn_right = 1'b0;
    run(20);
    check("repeat_count", right_q.size() - q0, 6);
    for (int i = 0; i < 6; i++) begin
      if (q0 + i < right_q.size())
        check($sformatf("repeat_cyc%0d", i), right_q[q0 + i], n0 + rep_off[i]);
      else
        check($sformatf("repeat_cyc%0d", i), -1, n0 + rep_off[i]);
    end
    check("repeat_state_rel", int'(bus.btn_state), 0);

    // Opposing fwd+bwd on the same edge
    c0 = pcnt[0]; c1 = pcnt[1]; n0 = cyc + 1;
    bus.btn_fwd = 1'b1; bus.btn_bwd = 1'b1;
    run(12);
    check("cont_fwd_cyc", last_cyc[0], n0 + LAT);
    check("cont_bwd_cyc", last_cyc[1], n0 + LAT + 2);
    check("cont_fwd_cnt", pcnt[0] - c0, 1);
    check("cont_bwd_cnt", pcnt[1] - c1, 1);
    bus.btn_fwd = 1'b0; bus.btn_bwd = 1'b0;
    run(10);

    // Opposing left+right on the same edge
    c2 = pcnt[2]; c3 = pcnt[3]; n0 = cyc + 1;
    bus.btn_left = 1'b1; bus.btn_right = 1'b1;
    run(12);
    check("cont_left_cyc", last_cyc[2], n0 + LAT);
    check("cont_right_cyc", last_cyc[3], n0 + LAT + 2);
    check("cont_lr_cnt", (pcnt[2] - c2) + (pcnt[3] - c3), 2);
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    run(10);

    // Async reset while the left request is pending
    c2 = pcnt[2]; n0 = cyc + 1;
    bus.btn_left = 1'b1;
    run(7);
    check("pre_rst_state", int'(bus.btn_state), 4);
    rst_in = 1'b1;
    #1;
    check("async_rst_state", int'(bus.btn_state), 0);
    check("async_rst_pulse", pulses_now(), 0);
    bus.btn_left = 1'b0;
    run(2);
    rst_in = 1'b0;
    run(20);
    check("rst_drop_left", pcnt[2] - c2, 0);

    // Button held through reset acts as a fresh press
    rst_in = 1'b1;
    bus.btn_right = 1'b1;
    run(3);
    c3 = pcnt[3]; n0 = cyc + 1;
    rst_in = 1'b0;
    run(12);
    check("held_rst_cyc", last_cyc[3], n0 + LAT);
    check("held_rst_cnt", pcnt[3] - c3, 1);
    bus.btn_right = 1'b0;
    run(10);

    check("gap_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
